// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared types and constants for the sequential BCD-to-binary
//             converter: digit width, default sizing, FSM state encoding,
//             BCD digit type and a digit-validity helper.
//  Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int DIGIT_W        = 4;
  localparam int DEF_NUM_DIGITS = 3;
  localparam int DEF_BIN_W      = 10;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd2bin_state_t;

  // A BCD nibble is only legal in the range 0..9.
  function automatic logic digit_invalid(input bcd_digit_t d);
    return (d > 4'd9);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_sub3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit_sub3
//  Purpose  : Per-digit correction step of reverse double dabble. A digit
//             that reads 8 or more after a right shift had a carried-in half
//             weight of 8 that is worth only 5 in decimal, so 3 is removed.
//  Ports    : digit     - 4-bit digit after the shift
//             corrected - digit after the conditional subtract-3
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_sub3
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  output bcd_digit_t corrected
);

  // 4-bit arithmetic only; no borrow propagates to neighbouring digits.
  assign corrected = (digit >= 4'd8) ? bcd_digit_t'(digit - 4'd3) : digit;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_to_bin_seq
//  Purpose  : Sequential BCD-to-binary converter (reverse double dabble).
//             Accepts a packed BCD value over a valid/ready handshake, runs
//             BIN_W shift/correct iterations (one per clock) and presents the
//             binary result over a valid/ready handshake.
//  Ports    : clk, rst          - clock (rising edge), async active-high reset
//             in_valid/in_ready - input handshake
//             in_bcd            - packed BCD, {hundreds, tens, ones}
//             out_valid/out_ready - output handshake
//             out_binary        - converted value, held until next result
//             out_err           - invalid-digit flag
//  Options  : BCD_RANGE_CHECK_EN - when defined, any nibble > 9 at accept
//             yields out_err=1 and out_binary=0; otherwise out_err is 0.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin_seq
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int BIN_W      = DEF_BIN_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] in_bcd,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [BIN_W-1:0]            out_binary,
  output logic                        out_err
);

  localparam int BCD_W = DIGIT_W * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W);

  bcd2bin_state_t   r_state;
  logic [BCD_W-1:0] r_bcd;
  logic [BIN_W-1:0] r_bin;
  logic [CNT_W-1:0] r_cnt;
  logic [BIN_W-1:0] r_out_binary;
  logic             r_out_valid;
  logic             r_in_ready;

  logic [BCD_W-1:0] w_bcd_shifted;
  logic [BCD_W-1:0] w_bcd_next;
  logic [BIN_W-1:0] w_bin_next;
  logic [BIN_W-1:0] w_result;
  logic             w_last;
  logic             w_accept;

  // The working register {bcd, bin} shifts right as a whole: the bcd LSB
  // falls into the bin MSB.
  assign w_bcd_shifted = r_bcd >> 1;
  assign w_bin_next    = {r_bcd[0], r_bin[BIN_W-1:1]};
  assign w_last        = (r_cnt == CNT_W'(BIN_W - 1));
  assign w_accept      = (r_state == IDLE) && in_valid;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_sub3 u_sub3 (
      .digit     (w_bcd_shifted[g*DIGIT_W +: DIGIT_W]),
      .corrected (w_bcd_next[g*DIGIT_W +: DIGIT_W])
    );
  end

`ifdef BCD_RANGE_CHECK_EN
  logic r_err;
  logic r_out_err;
  logic w_in_invalid;

  always_comb begin
    w_in_invalid = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_invalid(in_bcd[i*DIGIT_W +: DIGIT_W])) begin
        w_in_invalid = 1'b1;
      end
    end
  end

  // Error is latched at accept and only exposed once the result is final,
  // so latency is the same for good and bad inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_out_err <= 1'b0;
    end else if (w_accept) begin
      r_err     <= w_in_invalid;
      r_out_err <= 1'b0;
    end else if ((r_state == SHIFT) && w_last) begin
      r_out_err <= r_err;
    end
  end

  assign w_result = r_err ? '0 : w_bin_next;
  assign out_err  = r_out_err;
`else
  assign w_result = w_bin_next;
  assign out_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_bcd        <= '0;
      r_bin        <= '0;
      r_cnt        <= '0;
      r_out_binary <= '0;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_bcd      <= in_bcd;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= w_bin_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out_binary <= w_result;
            r_out_valid  <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          // A new in_valid here is not taken; acceptance waits for IDLE.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_binary = r_out_binary;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_to_bin_seq
//  Purpose  : Directed self-checking bench for bcd_to_bin_seq with
//             hand-computed expected values.
//  Options  : BCD_RANGE_CHECK_EN selects the invalid-digit expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_bcd = 12'h000;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [9:0]  out_binary;
  logic        out_err;

  int errors = 0;
  int checks = 0;
  int lat;

  bcd_to_bin_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_bcd     (in_bcd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_binary (out_binary),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a value at a negedge, let it be accepted, then count edges until
  // out_valid is seen (bounded).
  task automatic run(input logic [11:0] bcd, input string tag, output int n);
    @(negedge clk);
    in_bcd   = bcd;
    in_valid = 1'b1;
    check({tag, ".in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_bcd   = 12'h777;
    check({tag, ".busy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check({tag, ".latency"}, n, 10);
  endtask

  // Release the result and check the return to IDLE with the value retained.
  task automatic finish(input logic [9:0] exp, input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, ".valid_drop"}, out_valid, 0);
    check({tag, ".ready_back"}, in_ready, 1);
    check({tag, ".held"}, out_binary, exp);
  endtask

  initial begin
    // Reset state while rst is high.
    #12;
    check("rst.out_valid", out_valid, 0);
    check("rst.out_binary", out_binary, 0);
    check("rst.out_err", out_err, 0);
    check("rst.in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_rel.in_ready", in_ready, 1);
    check("rst_rel.out_valid", out_valid, 0);

    // Reset pulse in idle.
    rst = 1'b1;
    #2;
    check("idle_rst.in_ready", in_ready, 1);
    check("idle_rst.out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rst_rel.in_ready", in_ready, 1);

    // Conversions with out_ready held high, back-to-back.
    out_ready = 1'b1;
    run(12'h999, "c999", lat);
    check("c999.value", out_binary, 10'd999);
    check("c999.err", out_err, 0);
    finish(10'd999, "c999");
    run(12'h000, "c000", lat);
    check("c000.value", out_binary, 10'd0);
    finish(10'd0, "c000");
    run(12'h255, "c255", lat);
    check("c255.value", out_binary, 10'd255);
    finish(10'd255, "c255");
    run(12'h512, "c512", lat);
    check("c512.value", out_binary, 10'd512);
    finish(10'd512, "c512");

    // Backpressure: result held, ignored input pulses.
    out_ready = 1'b0;
    run(12'h128, "c128", lat);
    for (int i = 0; i < 5; i++) begin
      in_bcd   = 12'h777;
      in_valid = (i % 2 == 0);
      @(posedge clk);
      @(negedge clk);
      check("bp.valid", out_valid, 1);
      check("bp.value", out_binary, 10'd128);
      check("bp.in_ready", in_ready, 0);
    end
    // in_valid and out_ready together in DONE: only the return to IDLE.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_rel.valid", out_valid, 0);
    check("bp_rel.in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    check("bp_rel.not_taken", in_ready, 1);
    run(12'h486, "c486", lat);
    check("c486.value", out_binary, 10'd486);
    finish(10'd486, "c486");

    // Reset after the 4th shift.
    @(negedge clk);
    in_bcd   = 12'h640;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst.out_valid", out_valid, 0);
    check("mid_rst.in_ready", in_ready, 1);
    check("mid_rst.out_binary", out_binary, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_rst.no_result", out_valid, 0);
    check("mid_rst.idle", in_ready, 1);
    run(12'h033, "c033", lat);
    check("c033.value", out_binary, 10'd33);
    finish(10'd33, "c033");

    // Invalid digit handling.
    run(12'h1A3, "c1A3", lat);
`ifdef BCD_RANGE_CHECK_EN
    check("c1A3.err", out_err, 1);
    check("c1A3.value", out_binary, 10'd0);
    finish(10'd0, "c1A3");
`else
    check("c1A3.err", out_err, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("c1A3.valid_drop", out_valid, 0);
`endif
    run(12'h103, "c103", lat);
    check("c103.err", out_err, 0);
    check("c103.value", out_binary, 10'd103);
    finish(10'd103, "c103");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
